// File: rtl/aes_pkg.sv
// Shared AES-256 decryption constants, types and GF(2^8) round helpers.
package aes_pkg;

  localparam int NR      = 14;
  localparam int BLOCK_W = 128;
  localparam int RK_W    = 128;
  localparam int SCHED_W = (NR + 1) * RK_W;

  // Byte 0 sits in bits [0:7]; state is column-major (byte = row + 4*col).
  typedef logic [0:BLOCK_W-1] block_t;
  typedef logic [7:0]         byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (09/0b/0d/0e) using an xtime chain.
  function automatic byte_t gmul(byte_t a, logic [3:0] k);
    byte_t x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Row r rotates right by r columns.
  function automatic block_t inv_shift_rows(block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic block_t inv_mix_columns(block_t s);
    block_t o;
    byte_t  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[32*c + 8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[32*c + 16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[32*c + 24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Ciphertext-in / plaintext-out handshake bundle for aes_inv_cipher.
interface aes_inv_cipher_if;
  import aes_pkg::*;

  logic   v_i;
  block_t data_i;
  logic   ready_o;
  logic   v_o;
  block_t data_o;
  logic   yumi_i;

  // Producer/consumer side.
  modport master (output v_i, data_i, yumi_i, input ready_o, v_o, data_o);
  // Cipher side.
  modport slave  (input v_i, data_i, yumi_i, output ready_o, v_o, data_o);

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry n occupies bits [8n : 8n+7].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = INV_SBOX[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-256 inverse cipher: one round per clock, 14 rounds per block.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [0:SCHED_W-1] round_keys_i,
  aes_inv_cipher_if.slave    bus
);

  fsm_t       fsm_r;
  logic [3:0] cnt_r;
  block_t     state_r;
  logic       ready_r;
  logic       v_r;

  logic       last_round;
  logic [3:0] rk_idx;
  block_t     rk_cur;
  block_t     rk_last;
  block_t     shifted;
  block_t     subbed;
  block_t     added;
  block_t     round_out;

  // Counts 14/15 cannot occur; treat them like the final round so the FSM never sticks.
  assign last_round = (cnt_r == 4'd0) || (cnt_r > 4'd13);
  assign rk_idx     = last_round ? 4'd0 : cnt_r;
  assign rk_cur     = round_keys_i[{rk_idx, 7'd0} +: RK_W];
  assign rk_last    = round_keys_i[NR*RK_W +: RK_W];

  assign shifted = inv_shift_rows(state_r);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      aes_inv_sbox u_sbox (
        .in_byte  (shifted[8*gi +: 8]),
        .out_byte (subbed[8*gi +: 8])
      );
    end
  endgenerate

  assign added     = subbed ^ rk_cur;
  assign round_out = last_round ? added : inv_mix_columns(added);

  // Intermediate round values are masked so only finished plaintext is visible.
  assign bus.ready_o = ready_r;
  assign bus.v_o     = v_r;
  assign bus.data_o  = v_r ? state_r : '0;

  // Control FSM with registered handshake outputs and the round datapath register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fsm_r   <= IDLE;
      cnt_r   <= 4'd0;
      state_r <= '0;
      ready_r <= 1'b1;
      v_r     <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.v_i) begin
            state_r <= bus.data_i ^ rk_last;
            cnt_r   <= 4'd13;
            fsm_r   <= ROUND;
            ready_r <= 1'b0;
          end
        end
        ROUND: begin
          state_r <= round_out;
          if (last_round) begin
            cnt_r <= 4'd0;
            fsm_r <= DONE;
            v_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          if (bus.yumi_i) begin
            fsm_r   <= IDLE;
            v_r     <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          fsm_r   <= IDLE;
          cnt_r   <= 4'd0;
          ready_r <= 1'b1;
          v_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule
